// File: rtl/minterm_sweep_checker_pkg.sv
// sweep_pkg: shared definitions for the minterm sweep checker.
//   state_t  : sweep controller states (IDLE, DRIVE, SAMPLE, DONE)
//   TIMER_W  : width of the settle timer, enough for settle values up to 15
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int TIMER_W = 4;

endpackage

// File: rtl/minterm_sweep_checker_settle_timer.sv
// sweep_settle_timer: loadable down-counter that times how long a minterm is
// held on the DUT inputs before it is sampled.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   load        : load load_value (takes priority over enable)
//   enable      : count down by one per cycle while above 1
//   load_value  : value to load
//   expire      : high while the count sits at 1 (last hold cycle)
module sweep_settle_timer
    import sweep_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               enable,
    input  logic [TIMER_W-1:0] load_value,
    output logic               expire
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count > TIMER_W'(1))) begin
            // Saturate at 1 so a stalled controller keeps seeing expire.
            count <= count - TIMER_W'(1);
        end
    end

    assign expire = (count == TIMER_W'(1));

endmodule

// File: rtl/minterm_sweep_checker.sv
// minterm_sweep_checker: clocked stimulus generator and response checker for
// small combinational functions. Walks every minterm onto stim, holds each for
// SETTLE cycles, then compares two implementations against TRUTH.
// Parameters: N_IN (inputs), TRUTH (bit m = expected output at minterm m),
//             SETTLE (hold cycles before sampling, 1..15).
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   start       : pulse, begins a sweep from IDLE or DONE (ignored while busy)
//   stim        : minterm driven to the DUT, MSB is the first input
//   resp_a/b    : gate-form and expression-form responses
//   busy, done  : sweep in progress / sweep finished (held until start)
//   pass        : done with no mismatches (registered)
//   err_count   : number of failing minterms
//   first_err   : first failing minterm, valid while err_valid
// Optional build macro SWEEP_STOP_ON_ERR_EN: stop at the first mismatch and
// leave stim on the failing minterm.
module minterm_sweep_checker
    import sweep_pkg::*;
#(
    parameter int                     N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0]   TRUTH  = 4'b0010,
    parameter int                     SETTLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            resp_a,
    input  logic            resp_b,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err,
    output logic            err_valid
);

    localparam logic [TIMER_W-1:0] SETTLE_V = TIMER_W'(SETTLE);
    localparam logic [N_IN-1:0]    LAST_M   = {N_IN{1'b1}};

    state_t          state, state_n;
    logic [N_IN-1:0] stim_n, first_n;
    logic [N_IN:0]   cnt_n;
    logic            busy_n, done_n, pass_n, valid_n;
    logic            timer_load, timer_en, timer_expire;
    logic            mismatch, stop;

    sweep_settle_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .enable     (timer_en),
        .load_value (SETTLE_V),
        .expire     (timer_expire)
    );

    // A minterm counts once even when both implementations are wrong.
    assign mismatch = (resp_a != TRUTH[stim]) || (resp_b != TRUTH[stim]);

    always_comb begin
        state_n    = state;
        stim_n     = stim;
        busy_n     = busy;
        done_n     = done;
        pass_n     = pass;
        cnt_n      = err_count;
        first_n    = first_err;
        valid_n    = err_valid;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        stop       = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n    = DRIVE;
                    stim_n     = '0;
                    timer_load = 1'b1;
                    cnt_n      = '0;
                    first_n    = '0;
                    valid_n    = 1'b0;
                    busy_n     = 1'b1;
                    done_n     = 1'b0;
                    pass_n     = 1'b0;
                end
            end
            DRIVE: begin
                timer_en = 1'b1;
                if (timer_expire) begin
                    state_n = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    cnt_n = err_count + 1'b1;
                    if (!err_valid) begin
                        first_n = stim;
                        valid_n = 1'b1;
                    end
                end
`ifdef SWEEP_STOP_ON_ERR_EN
                stop = (stim == LAST_M) || mismatch;
`else
                stop = (stim == LAST_M);
`endif
                if (stop) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (cnt_n == '0);
                end else begin
                    stim_n     = stim + 1'b1;
                    timer_load = 1'b1;
                    state_n    = DRIVE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            stim      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            first_err <= '0;
            err_valid <= 1'b0;
        end else begin
            state     <= state_n;
            stim      <= stim_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
            err_count <= cnt_n;
            first_err <= first_n;
            err_valid <= valid_n;
        end
    end

endmodule

// File: doc/minterm_sweep_checker.md
Name: minterm_sweep_checker

Overview:
Sequential stimulus generator and response checker for the small combinational gate modules (f-style functions of N_IN inputs) that the guide exercises.
- Drives every minterm 0..2^N_IN-1 onto a DUT's inputs.
- Samples two implementations of the same function (gate-level and expression-level) and compares both against a golden truth-table parameter.
- Reports a mismatch count, the first failing minterm and pass/done status.
- Replaces the hand-written initial-block sweep with a clocked, reusable bench component.

Parameters:
N_IN, 2, number of DUT inputs; sweep covers 2^N_IN minterms.
TRUTH, 4'b0010, golden output; bit m = expected s at minterm m (default encodes a'.b); width 2^N_IN.
SETTLE, 1, cycles stim is held before sampling; legal range 1..15.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
start  input  1  pulse; begins a sweep from IDLE or DONE.
stim  output  N_IN  minterm driven to DUT inputs; MSB = first input (a).
resp_a  input  1  output of implementation A (gate form).
resp_b  input  1  output of implementation B (expression form).
busy  output  1  high from the cycle after start until the last sample.
done  output  1  high in DONE; held until next start or reset.
pass  output  1  done && err_count==0.
err_count  output  N_IN+1  number of minterms where resp_a or resp_b differs from TRUTH[m].
first_err  output  N_IN  minterm of first mismatch; valid when err_valid.
err_valid  output  1  set on first mismatch; cleared by start/reset.

Behaviour:
- Synchronous active-high reset on clk only, no async path. Reset values: state=IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_err=0, err_valid=0.
- Reset mid-sweep aborts immediately to IDLE with the reset values above.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: on start, go to DRIVE. Set stim=0 and settle timer=SETTLE. Clear err_count, first_err and err_valid. Set busy=1.
- DRIVE: decrement timer each cycle. When timer reaches 1, go to SAMPLE. stim holds for exactly SETTLE cycles.
- SAMPLE: one cycle; compare resp_a and resp_b, as seen at this clock edge, to TRUTH[stim].
  - On mismatch (either output differs): err_count += 1, counted once per minterm even if both differ.
  - If err_valid==0: first_err=stim and err_valid=1.
  - If stim==2^N_IN-1: go to DONE, busy=0, done=1.
  - Otherwise: stim+=1, reload timer, go to DRIVE.
- Latency: each minterm takes SETTLE+1 cycles. done rises (2^N_IN)*(SETTLE+1)+1 cycles after the start edge.
- DONE: stim holds the last minterm.
  - start restarts the sweep exactly as from IDLE (done drops the next cycle).
  - Without start, DONE is held indefinitely.
- start is ignored while busy. start coinciding with reset: reset wins.
- err_count cannot overflow: its maximum is 2^N_IN, which fits in N_IN+1 bits.
- pass is registered, computed on entry to DONE.

Optional Feature:
Macro SWEEP_STOP_ON_ERR_EN.
- Defined: the first mismatch in SAMPLE moves directly to DONE (busy=0, done=1, pass=0). err_count=1, first_err=failing minterm, and stim holds the failing minterm for debug.
- Not defined: the full sweep always runs to 2^N_IN-1, counting all mismatches.

Decomposition:
- Package sweep_pkg: state encoding constants (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3) and the settle-timer width constant (4 bits).
- One sub-module, sweep_settle_timer: loadable 4-bit down-counter with load, enable and expire outputs.
- FSM, minterm counter and error logic stay in the top module.

Test Plan:
- Pass case: defaults, DUT = correct a'.b pair, start at cycle 2 -> stim walks 0,1,2,3 at 2 cycles each; done=1, pass=1, err_count=0 at cycle 11; err_valid=0.
- Single fault: resp_b forced 1 at stim=2 -> err_count=1, first_err=2'b10, err_valid=1, pass=0.
- Double fault in one minterm: resp_a and resp_b both inverted at stim=1 only -> err_count=1 (not 2), first_err=1. Both outputs forced to 0 (DUT broken everywhere) -> err_count=1 since only minterm 1 expects 1.
- Timing: SETTLE=3 -> stim changes every 4 cycles; done rises 17 cycles after the start edge. start pulsed mid-sweep is ignored.
- Reset mid-sweep: reset at stim=2 -> next cycle all outputs 0, state IDLE. A fresh start then completes a full clean sweep.
- Stop-on-error: SWEEP_STOP_ON_ERR_EN defined, all-ones DUT -> DONE after the stim=0 sample; err_count=1, first_err=0, stim stays 0. Undefined: err_count=3 after the full sweep.
